// File: rtl/trace_pkg.sv
// Shared trace definitions: tag bit encodings and the beat layout on the trace bus.
package trace_pkg;

  localparam logic [3:0] TRACE_TAG_BRANCH = 4'b0001;
  localparam logic [3:0] TRACE_TAG_ADDR   = 4'b0010;
  localparam logic [3:0] TRACE_TAG_RSVD   = 4'b0100;
  localparam logic [3:0] TRACE_TAG_IRQ    = 4'b1000;

  localparam int unsigned TRACE_BEAT_W = 36;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] data;
  } trace_beat_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO. Occupancy is tracked by an explicit
// level counter so full/empty never depend on pointer equality.
module trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero while empty so stale storage never leaks out.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/trace_rx.sv
// Trace receiver: never stalls the core, queues beats for the host stream and
// keeps saturating per-tag and drop statistics with a sticky overflow flag.
module trace_rx
  import trace_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          trace_valid,
  input  logic [35:0]                   trace_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [3:0]                    out_tag,
  output logic [31:0]                   out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          clear_stats,
  output logic                          overflow,
  output logic [CNT_WIDTH-1:0]          cnt_branch,
  output logic [CNT_WIDTH-1:0]          cnt_addr,
  output logic [CNT_WIDTH-1:0]          cnt_irq,
  output logic [CNT_WIDTH-1:0]          cnt_rsvd,
  output logic [CNT_WIDTH-1:0]          cnt_drop
);

  trace_beat_t in_beat;
  trace_beat_t head_beat;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        push;
  logic        drop;

  logic [CNT_WIDTH-1:0] cnt_branch_q, cnt_branch_d;
  logic [CNT_WIDTH-1:0] cnt_addr_q,   cnt_addr_d;
  logic [CNT_WIDTH-1:0] cnt_irq_q,    cnt_irq_d;
  logic [CNT_WIDTH-1:0] cnt_rsvd_q,   cnt_rsvd_d;
  logic [CNT_WIDTH-1:0] cnt_drop_q,   cnt_drop_d;
  logic                 overflow_q,   overflow_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign in_beat   = trace_data;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push      = trace_valid && (!fifo_full || pop);
  assign drop      = trace_valid && fifo_full && !pop;

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TRACE_BEAT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_beat),
    .rdata (head_beat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign out_tag  = head_beat.tag;
  assign out_data = head_beat.data;

  // Statistics next-state: clear wins over any same-cycle event; tag bits
  // are decoded on arrival so dropped beats are still counted by tag.
  always_comb begin
    cnt_branch_d = cnt_branch_q;
    cnt_addr_d   = cnt_addr_q;
    cnt_irq_d    = cnt_irq_q;
    cnt_rsvd_d   = cnt_rsvd_q;
    cnt_drop_d   = cnt_drop_q;
    overflow_d   = overflow_q;
    if (clear_stats) begin
      cnt_branch_d = '0;
      cnt_addr_d   = '0;
      cnt_irq_d    = '0;
      cnt_rsvd_d   = '0;
      cnt_drop_d   = '0;
      overflow_d   = 1'b0;
    end else if (trace_valid) begin
      if ((in_beat.tag & TRACE_TAG_BRANCH) != '0) cnt_branch_d = sat_inc(cnt_branch_q);
      if ((in_beat.tag & TRACE_TAG_ADDR)   != '0) cnt_addr_d   = sat_inc(cnt_addr_q);
      if ((in_beat.tag & TRACE_TAG_RSVD)   != '0) cnt_rsvd_d   = sat_inc(cnt_rsvd_q);
      if ((in_beat.tag & TRACE_TAG_IRQ)    != '0) cnt_irq_d    = sat_inc(cnt_irq_q);
      if (drop) begin
        cnt_drop_d = sat_inc(cnt_drop_q);
        overflow_d = 1'b1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_branch_q <= '0;
      cnt_addr_q   <= '0;
      cnt_irq_q    <= '0;
      cnt_rsvd_q   <= '0;
      cnt_drop_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      cnt_branch_q <= cnt_branch_d;
      cnt_addr_q   <= cnt_addr_d;
      cnt_irq_q    <= cnt_irq_d;
      cnt_rsvd_q   <= cnt_rsvd_d;
      cnt_drop_q   <= cnt_drop_d;
      overflow_q   <= overflow_d;
    end
  end

  assign cnt_branch = cnt_branch_q;
  assign cnt_addr   = cnt_addr_q;
  assign cnt_irq    = cnt_irq_q;
  assign cnt_rsvd   = cnt_rsvd_q;
  assign cnt_drop   = cnt_drop_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_trace_rx.sv
// Directed bench for trace_rx: a default instance plus a CNT_WIDTH=4 instance
// sharing the same stimulus for the saturation case.
module tb_trace_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_valid;
  logic [35:0] trace_data;
  logic        out_ready;
  logic        clear_stats;

  logic        out_valid;
  logic [3:0]  out_tag;
  logic [31:0] out_data;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [15:0] cnt_branch, cnt_addr, cnt_irq, cnt_rsvd, cnt_drop;

  logic        out_valid4;
  logic [3:0]  out_tag4;
  logic [31:0] out_data4;
  logic [3:0]  fifo_level4;
  logic        overflow4;
  logic [3:0]  cnt_branch4, cnt_addr4, cnt_irq4, cnt_rsvd4, cnt_drop4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  trace_rx #(.FIFO_DEPTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .trace_valid(trace_valid), .trace_data(trace_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
    .fifo_level(fifo_level), .clear_stats(clear_stats), .overflow(overflow),
    .cnt_branch(cnt_branch), .cnt_addr(cnt_addr), .cnt_irq(cnt_irq),
    .cnt_rsvd(cnt_rsvd), .cnt_drop(cnt_drop)
  );

  trace_rx #(.FIFO_DEPTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .trace_valid(trace_valid), .trace_data(trace_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_tag(out_tag4), .out_data(out_data4),
    .fifo_level(fifo_level4), .clear_stats(clear_stats), .overflow(overflow4),
    .cnt_branch(cnt_branch4), .cnt_addr(cnt_addr4), .cnt_irq(cnt_irq4),
    .cnt_rsvd(cnt_rsvd4), .cnt_drop(cnt_drop4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [3:0] tag, input logic [31:0] data);
    trace_valid = 1'b1;
    trace_data  = {tag, data};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; trace_valid = 1'b0; trace_data = '0; out_ready = 1'b0; clear_stats = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_tag",   64'(out_tag),   64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_level",     64'(fifo_level), 64'd0);
    chk("rst_overflow",  64'(overflow),  64'd0);
    chk("rst_cnt_sum",   64'(cnt_branch) + 64'(cnt_addr) + 64'(cnt_irq) + 64'(cnt_rsvd) + 64'(cnt_drop), 64'd0);

    // 1: in-order streaming, one-cycle latency
    out_ready = 1'b1;
    beat(4'b0001, 32'h100);
    tick();
    chk("t1_v1",    64'(out_valid), 64'd1);
    chk("t1_tag1",  64'(out_tag),   64'h1);
    chk("t1_data1", 64'(out_data),  64'h100);
    chk("t1_lvl1",  64'(fifo_level), 64'd1);
    beat(4'b0010, 32'h2000);
    tick();
    chk("t1_tag2",  64'(out_tag),   64'h2);
    chk("t1_data2", 64'(out_data),  64'h2000);
    chk("t1_lvl2",  64'(fifo_level), 64'd1);
    beat(4'b1000, 32'h10);
    tick();
    chk("t1_tag3",  64'(out_tag),   64'h8);
    chk("t1_data3", 64'(out_data),  64'h10);
    trace_valid = 1'b0;
    tick();
    chk("t1_empty_valid", 64'(out_valid), 64'd0);
    chk("t1_empty_data",  64'(out_data),  64'd0);
    chk("t1_empty_level", 64'(fifo_level), 64'd0);
    chk("t1_branch",   64'(cnt_branch), 64'd1);
    chk("t1_addr",     64'(cnt_addr),   64'd1);
    chk("t1_irq",      64'(cnt_irq),    64'd1);
    chk("t1_overflow", 64'(overflow),   64'd0);

    // 2: fill with out_ready low, 10 beats into 8 entries
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      beat(4'b0000, 32'(i));
      tick();
    end
    trace_valid = 1'b0;
    chk("t2_level",    64'(fifo_level), 64'd8);
    chk("t2_drop",     64'(cnt_drop),   64'd2);
    chk("t2_overflow", 64'(overflow),   64'd1);
    chk("t2_head",     64'(out_data),   64'd0);
    tick();
    chk("t2_head_stable", 64'(out_data), 64'd0);

    // 3: full with simultaneous push and pop
    out_ready = 1'b1;
    beat(4'b0000, 32'hAA);
    tick();
    trace_valid = 1'b0;
    out_ready   = 1'b0;
    chk("t3_level", 64'(fifo_level), 64'd8);
    chk("t3_drop",  64'(cnt_drop),   64'd2);
    chk("t3_head",  64'(out_data),   64'd1);
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("t3_drain%0d", i), 64'(out_data), 64'(i));
      tick();
    end
    chk("t3_tail_valid", 64'(out_valid), 64'd1);
    chk("t3_tail_data",  64'(out_data),  64'hAA);
    tick();
    chk("t3_empty", 64'(out_valid), 64'd0);

    // 4: multi-bit tag and reserved tag
    beat(4'b1001, 32'h55);
    tick();
    chk("t4_irq",    64'(cnt_irq),    64'd2);
    chk("t4_branch", 64'(cnt_branch), 64'd2);
    chk("t4_tag9",   64'(out_tag),    64'h9);
    beat(4'b0100, 32'h44);
    tick();
    trace_valid = 1'b0;
    chk("t4_rsvd",     64'(cnt_rsvd),  64'd1);
    chk("t4_rsvd_tag", 64'(out_tag),   64'h4);
    chk("t4_rsvd_dat", 64'(out_data),  64'h44);
    chk("t4_addr",     64'(cnt_addr),  64'd1);
    tick();
    chk("t4_empty", 64'(out_valid), 64'd0);

    // 5: clear_stats concurrent with a branch beat
    out_ready   = 1'b0;
    clear_stats = 1'b1;
    beat(4'b0001, 32'h77);
    tick();
    clear_stats = 1'b0;
    trace_valid = 1'b0;
    chk("t5_cnt_sum", 64'(cnt_branch) + 64'(cnt_addr) + 64'(cnt_irq) + 64'(cnt_rsvd) + 64'(cnt_drop), 64'd0);
    chk("t5_branch",   64'(cnt_branch), 64'd0);
    chk("t5_overflow", 64'(overflow),   64'd0);
    chk("t5_level",    64'(fifo_level), 64'd1);
    chk("t5_data",     64'(out_data),   64'h77);
    out_ready = 1'b1;
    tick();
    chk("t5_empty", 64'(out_valid), 64'd0);

    // 6: saturation on the 4-bit instance, then reset with beats queued
    for (int i = 0; i < 20; i++) begin
      beat(4'b0001, 32'(i));
      tick();
      if (i == 13) chk("t6_sat14", 64'(cnt_branch4), 64'd14);
      if (i == 14) chk("t6_sat15", 64'(cnt_branch4), 64'd15);
    end
    trace_valid = 1'b0;
    chk("t6_sat_hold", 64'(cnt_branch4), 64'd15);
    chk("t6_wide_cnt", 64'(cnt_branch),  64'd20);
    chk("t6_data19",   64'(out_data),    64'd19);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(4'b0010, 32'(32'h300 + i));
      tick();
    end
    chk("t6_q3_level", 64'(fifo_level), 64'd3);
    chk("t6_q3_valid", 64'(out_valid),  64'd1);
    reset = 1'b1;
    beat(4'b0001, 32'hDEAD);
    tick();
    reset = 1'b0;
    trace_valid = 1'b0;
    chk("t6_rst_valid",  64'(out_valid),   64'd0);
    chk("t6_rst_level",  64'(fifo_level),  64'd0);
    chk("t6_rst_data",   64'(out_data),    64'd0);
    chk("t6_rst_cnt",    64'(cnt_branch),  64'd0);
    chk("t6_rst_level4", 64'(fifo_level4), 64'd0);
    tick();
    chk("t6_post_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
